safe_lock_controller: RTL and testbench

Sequencing FSM for the digital safe lock. It consumes the keypad encoder's code/valid pair and debounces it into one event per key press. It collects a fixed-length PIN, compares it against a stored PIN, and drives the unlock output. It also enforces a lockout after repeated failures and allows changing the PIN while the safe is open.

---
 rtl/safe_lock_controller_pkg.sv | 18 +
 rtl/safe_lock_controller_key_event_detector.sv | 57 +++++
 rtl/safe_lock_controller.sv | 171 +++++++++++++++++
 tb/tb_safe_lock_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/safe_lock_controller_pkg.sv
// Shared definitions for the safe lock: keypad control codes and FSM state encoding.
package safe_lock_controller_pkg;

   localparam logic [3:0] KEY_CLEAR = 4'd10;
   localparam logic [3:0] KEY_ENTER = 4'd11;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      CHECK   = 2'd1,
      OPEN    = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/safe_lock_controller_key_event_detector.sv
// Debounces the encoder code/valid pair into a single strobe per key press, re-armed by a stable release.
module key_event_detector
   import safe_lock_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       event_strobe,
   output logic [3:0] event_code
);

   localparam int            RW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(DEBOUNCE_CYCLES);

   logic          last_v;
   logic [3:0]    last_c;
   logic [RW-1:0] run_q, run_d;
   logic          armed;
   logic          same;

   // Released samples compare equal regardless of the code lines.
   always_comb begin
      same  = (key_valid == last_v) && (!key_valid || key_code == last_c);
      run_d = RW'(1);
      if (same) run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_v       <= 1'b0;
         last_c       <= 4'd0;
         run_q        <= '0;
         armed        <= 1'b1;
         event_strobe <= 1'b0;
         event_code   <= 4'd0;
      end else begin
         last_v       <= key_valid;
         last_c       <= key_code;
         run_q        <= run_d;
         event_strobe <= 1'b0;
         if (run_d == RUN_MAX) begin
            if (key_valid && armed) begin
               // Undefined codes still consume the press so they cannot fire later.
               armed        <= 1'b0;
               event_strobe <= (key_code <= KEY_ENTER);
               event_code   <= key_code;
            end else if (!key_valid) begin
               armed <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/safe_lock_controller.sv
// Safe lock sequencer: PIN entry, check, open window with PIN change, and lockout after repeated failures.
module safe_lock_controller
   import safe_lock_controller_pkg::*;
#(
   parameter int                   PIN_LEN         = 4,
   parameter int                   MAX_ATTEMPTS    = 3,
   parameter int                   DEBOUNCE_CYCLES = 4,
   parameter int                   UNLOCK_CYCLES   = 1000,
   parameter int                   LOCKOUT_CYCLES  = 5000,
   parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN     = 16'h1234
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       unlocked,
   output logic       locked_out,
   output logic       err_pulse,
   output logic       pin_changed,
   output logic [3:0] digit_count,
   output logic [3:0] attempts_left
);

   localparam int            BW       = 4 * PIN_LEN;
   localparam int            TMAX     = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int            TW       = $clog2(TMAX + 1);
   localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES);
   localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES);
   localparam logic [3:0]    LEN_C    = 4'(PIN_LEN);
   localparam logic [3:0]    MAX_C    = 4'(MAX_ATTEMPTS);

   logic          ev;
   logic [3:0]    ev_code;
   logic          ev_dig, ev_clr, ev_ent;

   state_t        state_q, state_d;
   logic [BW-1:0] buf_q, buf_d, pin_q, pin_d;
   logic [3:0]    cnt_q, cnt_d, fail_q, fail_d;
   logic          ovf_q, ovf_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          err_d, chg_d, edit, full;

   key_event_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ked (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_code     (key_code),
      .key_valid    (key_valid),
      .event_strobe (ev),
      .event_code   (ev_code)
   );

   assign ev_dig      = ev && is_digit(ev_code);
   assign ev_clr      = ev && (ev_code == KEY_CLEAR);
   assign ev_ent      = ev && (ev_code == KEY_ENTER);
   assign full        = (cnt_q == LEN_C) && !ovf_q;
   assign digit_count = cnt_q;

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      fail_d  = fail_q;
      pin_d   = pin_q;
      timer_d = timer_q;
      err_d   = 1'b0;
      chg_d   = 1'b0;
      edit    = 1'b0;
      case (state_q)
         ENTRY: begin
            edit = 1'b1;
            if (ev_ent) state_d = CHECK;
         end
         CHECK: begin
            buf_d = '0;
            cnt_d = 4'd0;
            ovf_d = 1'b0;
            if (full && buf_q == pin_q) begin
               state_d = OPEN;
               fail_d  = 4'd0;
               timer_d = T_UNLOCK;
            end else begin
               err_d  = 1'b1;
               fail_d = fail_q + 4'd1;
               if (fail_q + 4'd1 == MAX_C) begin
                  state_d = LOCKOUT;
                  timer_d = T_LOCK;
               end else begin
                  state_d = ENTRY;
               end
            end
         end
         OPEN: begin
            // Expiry takes priority over a key event landing in the same cycle.
            if (timer_q == TW'(1)) begin
               state_d = ENTRY;
               buf_d   = '0;
               cnt_d   = 4'd0;
               ovf_d   = 1'b0;
            end else begin
               timer_d = ev ? T_UNLOCK : timer_q - TW'(1);
               edit    = 1'b1;
               if (ev_ent) begin
                  if (full) begin
                     pin_d = buf_q;
                     chg_d = 1'b1;
                  end
                  state_d = ENTRY;
                  buf_d   = '0;
                  cnt_d   = 4'd0;
                  ovf_d   = 1'b0;
               end
            end
         end
         LOCKOUT: begin
            if (timer_q == TW'(1)) begin
               state_d = ENTRY;
               fail_d  = 4'd0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = ENTRY;
      endcase
      if (edit) begin
         if (ev_dig) begin
            if (cnt_q < LEN_C) begin
               buf_d = (buf_q << 4) | BW'(ev_code);
               cnt_d = cnt_q + 4'd1;
            end else begin
               ovf_d = 1'b1;
            end
         end else if (ev_clr) begin
            buf_d = '0;
            cnt_d = 4'd0;
            ovf_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ENTRY;
         buf_q         <= '0;
         cnt_q         <= 4'd0;
         ovf_q         <= 1'b0;
         fail_q        <= 4'd0;
         pin_q         <= DEFAULT_PIN;
         timer_q       <= '0;
         unlocked      <= 1'b0;
         locked_out    <= 1'b0;
         err_pulse     <= 1'b0;
         pin_changed   <= 1'b0;
         attempts_left <= MAX_C;
      end else begin
         state_q       <= state_d;
         buf_q         <= buf_d;
         cnt_q         <= cnt_d;
         ovf_q         <= ovf_d;
         fail_q        <= fail_d;
         pin_q         <= pin_d;
         timer_q       <= timer_d;
         unlocked      <= (state_d == OPEN);
         locked_out    <= (state_d == LOCKOUT);
         err_pulse     <= err_d;
         pin_changed   <= chg_d;
         attempts_left <= MAX_C - fail_d;
      end
   end

endmodule

// File: tb/tb_safe_lock_controller.sv
// Bench for safe_lock_controller: directed test-plan scenarios plus random key traffic against a behavioural model.
module tb_safe_lock_controller;

   localparam int          PIN_LEN = 4;
   localparam int          MAX_ATT = 3;
   localparam int          DEB     = 2;
   localparam int          UNL     = 20;
   localparam int          LCK     = 30;
   localparam logic [15:0] DEF_PIN = 16'h1234;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       key_valid = 1'b0;
   logic       unlocked, locked_out, err_pulse, pin_changed;
   logic [3:0] digit_count, attempts_left;

   safe_lock_controller #(
      .PIN_LEN(PIN_LEN), .MAX_ATTEMPTS(MAX_ATT), .DEBOUNCE_CYCLES(DEB),
      .UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK), .DEFAULT_PIN(DEF_PIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
      .unlocked(unlocked), .locked_out(locked_out), .err_pulse(err_pulse),
      .pin_changed(pin_changed), .digit_count(digit_count), .attempts_left(attempts_left)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int PH_ENTRY = 0, PH_CHECK = 1, PH_OPEN = 2, PH_LOCK = 3;
   localparam int IDLE_SAMPLE = 16;

   int ph, fails, anchor, cyc, evc;
   bit ovf, armed, ev, m_err, m_chg, stable, match;
   int digs[$];
   int pin[$];
   int hist[$];

   task automatic model_reset();
      ph = PH_ENTRY;
      digs.delete();
      ovf = 1'b0;
      fails = 0;
      pin.delete();
      for (int i = 0; i < PIN_LEN; i++) pin.push_back((int'(DEF_PIN) >> (4 * (PIN_LEN - 1 - i))) & 15);
      hist.delete();
      armed = 1'b1;
      ev = 1'b0;
      evc = 0;
      m_err = 1'b0;
      m_chg = 1'b0;
   endtask

   task automatic edit_buf(input int c);
      if (c <= 9) begin
         if (digs.size() < PIN_LEN) digs.push_back(c);
         else ovf = 1'b1;
      end else if (c == 10) begin
         digs.delete();
         ovf = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         m_err = 1'b0;
         m_chg = 1'b0;
         case (ph)
            PH_ENTRY: if (ev) begin
               if (evc == 11) ph = PH_CHECK;
               else edit_buf(evc);
            end
            PH_CHECK: begin
               match = (digs.size() == PIN_LEN) && !ovf;
               if (match) for (int i = 0; i < PIN_LEN; i++) if (digs[i] != pin[i]) match = 1'b0;
               digs.delete();
               ovf = 1'b0;
               if (match) begin
                  ph = PH_OPEN;
                  anchor = cyc + 1;
                  fails = 0;
               end else begin
                  m_err = 1'b1;
                  fails++;
                  if (fails == MAX_ATT) begin
                     ph = PH_LOCK;
                     anchor = cyc + 1;
                  end else ph = PH_ENTRY;
               end
            end
            PH_OPEN: begin
               if (cyc - anchor == UNL - 1) begin
                  ph = PH_ENTRY;
                  digs.delete();
                  ovf = 1'b0;
               end else if (ev) begin
                  anchor = cyc + 1;
                  if (evc == 11) begin
                     if (digs.size() == PIN_LEN && !ovf) begin
                        pin = digs;
                        m_chg = 1'b1;
                     end
                     digs.delete();
                     ovf = 1'b0;
                     ph = PH_ENTRY;
                  end else edit_buf(evc);
               end
            end
            default: if (cyc - anchor == LCK - 1) begin
               ph = PH_ENTRY;
               fails = 0;
            end
         endcase
         // A key is accepted when the last DEB samples are identical and pressed.
         hist.push_back(key_valid ? int'(key_code) : IDLE_SAMPLE);
         if (hist.size() > DEB) void'(hist.pop_front());
         stable = (hist.size() == DEB);
         foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
         ev = 1'b0;
         if (stable) begin
            if (hist[0] != IDLE_SAMPLE && armed) begin
               armed = 1'b0;
               if (hist[0] <= 11) begin
                  ev = 1'b1;
                  evc = hist[0];
               end
            end else if (hist[0] == IDLE_SAMPLE) armed = 1'b1;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("unlocked", int'(unlocked), int'(ph == PH_OPEN));
         chk("locked_out", int'(locked_out), int'(ph == PH_LOCK));
         chk("err_pulse", int'(err_pulse), int'(m_err));
         chk("pin_changed", int'(pin_changed), int'(m_chg));
         chk("digit_count", int'(digit_count), digs.size());
         chk("attempts_left", int'(attempts_left), MAX_ATT - fails);
      end
   end

   // ---------------- stimulus ----------------
   task automatic press(input int code, input int hold = 4, input int rel = 4);
      for (int i = 0; i < hold; i++) begin
         key_valid = 1'b1;
         key_code  = 4'(code);
         @(posedge clk); #1;
      end
      for (int i = 0; i < rel; i++) begin
         key_valid = 1'b0;
         key_code  = 4'($urandom_range(0, 15));
         @(posedge clk); #1;
      end
   endtask

   task automatic enter4(input int a, input int b, input int c, input int d);
      press(a); press(b); press(c); press(d); press(11);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_unlocked", int'(unlocked), 0);
      chk("rst_locked_out", int'(locked_out), 0);
      chk("rst_digit_count", int'(digit_count), 0);
      chk("rst_attempts", int'(attempts_left), MAX_ATT);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int p[$];
      int r;
      model_reset();
      cyc = 0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      idle(2);

      // default PIN opens, then the window times out
      enter4(1, 2, 3, 4);
      chk("t1_unlocked", int'(unlocked), 1);
      idle(UNL + 5);
      chk("t1_relocked", int'(unlocked), 0);

      // three wrong entries lock out; keys ignored while locked
      enter4(1, 2, 3, 5);
      chk("t2_att2", int'(attempts_left), 2);
      enter4(1, 2, 3, 5);
      chk("t2_att1", int'(attempts_left), 1);
      enter4(1, 2, 3, 5);
      chk("t2_att0", int'(attempts_left), 0);
      chk("t2_locked", int'(locked_out), 1);
      press(5);
      chk("t2_ignored", int'(digit_count), 0);
      idle(LCK);
      chk("t2_released", int'(locked_out), 0);
      chk("t2_att_restored", int'(attempts_left), 3);

      // long hold with an early valid glitch gives one digit
      key_valid = 1'b1; key_code = 4'd7; @(posedge clk); #1;
      key_valid = 1'b0; @(posedge clk); #1;
      press(7, 48, 4);
      chk("t3_one_digit", int'(digit_count), 1);
      press(10);
      chk("t3_cleared", int'(digit_count), 0);

      // PIN change while open
      enter4(1, 2, 3, 4);
      enter4(9, 8, 7, 6);
      chk("t4_relock", int'(unlocked), 0);
      enter4(1, 2, 3, 4);
      chk("t4_old_fails", int'(attempts_left), 2);
      enter4(9, 8, 7, 6);
      chk("t4_new_opens", int'(unlocked), 1);
      do_reset();
      enter4(1, 2, 3, 4);
      chk("t4_default_back", int'(unlocked), 1);
      idle(UNL + 5);

      // overflow fails, CLEAR recovers
      press(1); press(2); press(3); press(4); press(5); press(11);
      chk("t5_overflow_fail", int'(attempts_left), 2);
      press(1); press(2); press(10);
      enter4(1, 2, 3, 4);
      chk("t5_clear_opens", int'(unlocked), 1);
      idle(UNL + 5);

      // reset in the middle of lockout
      enter4(0, 0, 0, 0); enter4(0, 0, 0, 0); enter4(0, 0, 0, 0);
      chk("t6_locked", int'(locked_out), 1);
      do_reset();
      enter4(1, 2, 3, 4);
      chk("t6_opens", int'(unlocked), 1);
      idle(UNL + 5);

      // random traffic
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 19);
         if (r < 3) begin
            p = pin;
            foreach (p[i]) press(p[i], $urandom_range(2, 4), $urandom_range(2, 4));
            press(11, $urandom_range(2, 4), $urandom_range(2, 4));
         end else if (r < 5) begin
            key_valid = 1'b1; key_code = 4'($urandom_range(0, 11)); @(posedge clk); #1;
            key_valid = 1'b0; @(posedge clk); #1;
            press(int'(key_code), $urandom_range(1, 5), $urandom_range(1, 5));
         end else if (r < 6) begin
            idle($urandom_range(1, 25));
         end else begin
            press($urandom_range(0, 15), $urandom_range(1, 5), $urandom_range(1, 5));
         end
      end
      idle(LCK + 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
